pulse_window_counter: RTL and testbench

Downstream consumer for the single-bit Mealy detector output. It counts `pulse_in` cycles over a fixed window of `WINDOW` clocks, then presents the count to a host through a valid/ready handshake. It sits between the detector's `dout` and the status/readout logic. Counts saturate, and overflow is flagged.

---
 rtl/pulse_window_counter_pkg.sv | 13 +
 rtl/pulse_window_counter_window_timer.sv | 37 +++
 rtl/pulse_window_counter.sv | 123 ++++++++++++
 tb/tb_pulse_window_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_window_counter_pkg.sv
// Shared definitions for pulse_window_counter.
// Holds the FSM state width and the state encodings used by the top.
package pulse_window_counter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_window_counter_window_timer.sv
// window_timer: counts the clocks of one measurement window.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   clr  - synchronous clear of the timer
//   en   - advance the timer by one this cycle
//   last - high while the timer sits at WINDOW-1
// The timer parks at WINDOW-1 instead of wrapping; the owner clears it
// before the next window starts.
module window_timer #(
  parameter int WINDOW = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [TW-1:0] LAST_VAL = TW'(WINDOW - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/pulse_window_counter.sv
// pulse_window_counter: counts pulse_in cycles over a WINDOW-clock window
// and hands the saturated count to a host over a valid/ready handshake.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - request a measurement window (honoured in IDLE, or in
//               REPORT together with the handshake for back-to-back windows)
//   pulse_in  - event input, counted only while a window is open
//   rdy       - host accepts the result
//   count_out - event count of the last completed window
//   valid     - count_out holds a result not yet accepted
//   busy      - a window is in progress
//   overflow  - the accumulator saturated during the reported window
module pulse_window_counter
  import pulse_window_counter_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pulse_in,
  input  logic             rdy,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  // Saturating increment: holds at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                               input logic inc);
    if (inc && (a != ACC_MAX)) return a + 1'b1;
    return a;
  endfunction

  // A pulse arriving while the accumulator is already at full scale is lost.
  function automatic logic sat_hit(input logic [CNT_W-1:0] a, input logic inc);
    return inc && (a == ACC_MAX);
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
  logic             ovf_acc;
  logic             ovf_nxt;
  logic             in_count;

  assign in_count = (state == ST_COUNT);

  window_timer #(
    .WINDOW (WINDOW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_count),
    .en   (in_count),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (last) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        if (rdy) state_nxt = start ? ST_COUNT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The final window cycle's pulse must land in the result, so the output
  // registers load from the next-value of the accumulator, not its state.
  assign acc_nxt = sat_inc(acc, pulse_in);
  assign ovf_nxt = ovf_acc | sat_hit(acc, pulse_in);

  // Accumulator is held at zero outside COUNT, which discards pulses in
  // IDLE/REPORT and gives back-to-back windows a clean start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (in_count) begin
      acc     <= acc_nxt;
      ovf_acc <= ovf_nxt;
    end else begin
      acc     <= '0;
      ovf_acc <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
      overflow  <= 1'b0;
    end else if (in_count && last) begin
      count_out <= acc_nxt;
      overflow  <= ovf_nxt;
    end
  end

  assign valid = (state == ST_REPORT);
  assign busy  = in_count;

endmodule

// File: tb/tb_pulse_window_counter.sv
module tb_pulse_window_counter;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pulse_in;
  logic       rdy;
  logic [7:0] c8;
  logic       v8, b8, o8;
  logic [3:0] c4;
  logic       v4, b4, o4;

  int n_cmp = 0;
  int n_mis = 0;

  // last result the host should be seeing, per instance
  int prev8  = 0;
  int prevo8 = 0;
  int prev4  = 0;
  int prevo4 = 0;

  always #5 clk = ~clk;

  pulse_window_counter #(.WINDOW(W), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .pulse_in(pulse_in), .rdy(rdy),
    .count_out(c8), .valid(v8), .busy(b8), .overflow(o8)
  );

  pulse_window_counter #(.WINDOW(W), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .pulse_in(pulse_in), .rdy(rdy),
    .count_out(c4), .valid(v4), .busy(b4), .overflow(o4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result of one window: number of pulses, saturated to the
  // counter width; overflow when more pulses arrived than full scale holds.
  function automatic int ref_cnt(input logic [W-1:0] pat, input int cw);
    int n   = $countones(pat);
    int max = (1 << cw) - 1;
    return (n > max) ? max : n;
  endfunction

  function automatic int ref_ovf(input logic [W-1:0] pat, input int cw);
    return ($countones(pat) > ((1 << cw) - 1)) ? 1 : 0;
  endfunction

  // From IDLE: present start for one cycle; returns #1 after edge E0.
  task automatic start_idle(input logic pre);
    start    = 1'b1;
    pulse_in = pre;
    step();
    start    = 1'b0;
  endtask

  // Drives the W counting cycles. start is toggled randomly to show it is
  // ignored. Ends #1 after edge E0+W, where the result must be valid.
  task automatic count_phase(input logic [W-1:0] pat);
    for (int i = 0; i < W; i++) begin
      pulse_in = pat[i];
      start    = 1'($urandom_range(0, 1));
      chk("busy_in_window", b8, 1);
      chk("valid_in_window", v8, 0);
      chk("busy4_in_window", b4, 1);
      chk("hold_count_in_window", c8, prev8);
      chk("hold_count4_in_window", c4, prev4);
      step();
    end
    start = 1'b0;
  endtask

  // Checks the result, stalls with rdy low, then completes the handshake,
  // optionally with start for a back-to-back window.
  task automatic report_phase(input logic [W-1:0] pat, input int stall,
                              input logic chain, input logic rpulse);
    prev8  = ref_cnt(pat, 8);
    prevo8 = ref_ovf(pat, 8);
    prev4  = ref_cnt(pat, 4);
    prevo4 = ref_ovf(pat, 4);
    pulse_in = rpulse;
    chk("valid_at_latency", v8, 1);
    chk("busy_in_report", b8, 0);
    chk("count8", c8, prev8);
    chk("ovf8", o8, prevo8);
    chk("valid4_at_latency", v4, 1);
    chk("count4", c4, prev4);
    chk("ovf4", o4, prevo4);
    for (int i = 0; i < stall; i++) begin
      rdy      = 1'b0;
      pulse_in = 1'($urandom_range(0, 1));
      step();
      chk("valid_stall", v8, 1);
      chk("count_stall", c8, prev8);
      chk("count4_stall", c4, prev4);
      chk("ovf4_stall", o4, prevo4);
    end
    rdy   = 1'b1;
    start = chain;
    step();
    rdy      = 1'b0;
    start    = 1'b0;
    pulse_in = 1'b0;
    chk("valid_after_hs", v8, 0);
    chk("busy_after_hs", b8, int'(chain));
    chk("count_after_hs", c8, prev8);
    chk("ovf4_after_hs", o4, prevo4);
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] pat2;
    logic         chain;
    rst      = 1'b1;
    start    = 1'b0;
    pulse_in = 1'b0;
    rdy      = 1'b0;
    step();
    step();
    chk("rst_count", c8, 0);
    chk("rst_valid", v8, 0);
    chk("rst_busy", b8, 0);
    chk("rst_ovf", o8, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", b8, 0);

    // five scattered pulses
    pat = 16'b0100_0010_0001_0100 | 16'h0800;
    start_idle(1'b0);
    count_phase(pat);
    report_phase(pat, 0, 1'b0, 1'b0);
    step();
    chk("idle_after_report", b8, 0);

    // first and last cycles, plus ignored pulses before start and in REPORT
    pat = 16'h8001;
    pulse_in = 1'b1;
    step();
    start_idle(1'b1);
    count_phase(pat);
    report_phase(pat, 2, 1'b0, 1'b1);

    // saturation on the narrow counter, then a clean back-to-back window
    pat = 16'hFFFF;
    start_idle(1'b0);
    count_phase(pat);
    report_phase(pat, 0, 1'b1, 1'b0);
    pat = 16'h0124;
    count_phase(pat);
    // long stall, then handshake with start: no IDLE cycle in between
    report_phase(pat, 10, 1'b1, 1'b1);
    pat2 = 16'h00F0;
    count_phase(pat2);
    report_phase(pat2, 1, 1'b0, 1'b0);

    // asynchronous reset in the middle of a window
    start_idle(1'b0);
    for (int i = 0; i < 8; i++) begin
      pulse_in = 1'b1;
      step();
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", c8, 0);
    chk("async_rst_busy", b8, 0);
    chk("async_rst_valid", v8, 0);
    chk("async_rst_count4", c4, 0);
    chk("async_rst_ovf4", o4, 0);
    pulse_in = 1'b0;
    step();
    rst = 1'b0;
    prev8 = 0; prevo8 = 0; prev4 = 0; prevo4 = 0;
    step();
    pat = 16'h1010 | 16'h0002;
    start_idle(1'b0);
    count_phase(pat);
    report_phase(pat, 0, 1'b0, 1'b0);

    // randomized windows
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 5))
        0:       pat = 16'hFFFF;
        1:       pat = 16'h0000;
        default: pat = 16'($urandom);
      endcase
      chain = 1'($urandom_range(0, 1));
      if (!b8) start_idle(1'($urandom_range(0, 1)));
      count_phase(pat);
      report_phase(pat, $urandom_range(0, 3), chain, 1'($urandom_range(0, 1)));
      if (!chain) begin
        repeat ($urandom_range(0, 2)) step();
      end
    end
    if (b8) begin
      count_phase(16'h0003);
      report_phase(16'h0003, 0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
